speck_decrypt_iter: RTL and testbench



---
 rtl/speck_decrypt_iter.sv | 162 ++++++++++++++++
 tb/tb_speck_decrypt_iter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/speck_decrypt_iter.sv
// speck_decrypt_iter
// Iterative SPECK32/64 decryption. A ciphertext/key pair is accepted in IDLE.
// The round keys are then expanded one per cycle (EXPAND) and the inverse
// rounds run last-to-first, one per cycle (DECRYPT). The plaintext is held in
// DONE until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer keeps valid (and data) until that edge, and ready
// may depend on state only. in_valid is ignored while in_ready is 0. pt stays
// stable while out_valid is 1 and out_ready is 0.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   ct/key input handshake, in_ready=1 only in IDLE
//   ct[31:0]            ciphertext {x, y}
//   key[63:0]           {l2, l1, l0, k0}
//   out_valid/out_ready plaintext output handshake
//   pt[31:0]            plaintext {x, y}
//   debug_round[4:0]    expansion index in EXPAND, round index in DECRYPT, else 0
module speck_decrypt_iter #(
    parameter int ROUNDS = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ct,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pt,
    output logic [4:0]  debug_round
);

    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;

    // For ROUNDS=1 LAST_EXP wraps, but EXPAND is never entered in that case.
    localparam logic [4:0] LAST_EXP = 5'(ROUNDS - 2);
    localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [47:0] l_q, l_d;   // l window, [15:0] is the oldest word l_i
    logic [31:0] pt_q, pt_d;
    logic [15:0] rk_q [ROUNDS];

    logic        rk_we;
    logic [4:0]  rk_waddr;
    logic [15:0] rk_wdata;
    logic [15:0] rk_sel;
    logic [15:0] lnew, rk_new;
    logic [15:0] xy, y_inv, x_sub, x_inv;

    // rk[cnt] serves both phases: rk[i] during expansion, rk[r] during decryption.
    always_comb begin
        rk_sel = '0;
        for (int j = 0; j < ROUNDS; j++) begin
            if (cnt_q == 5'(j)) rk_sel = rk_q[j];
        end
    end

    // Key schedule step and inverse round.
    always_comb begin
        lnew   = (rk_sel + {l_q[6:0], l_q[15:7]}) ^ {11'd0, cnt_q};
        rk_new = {rk_sel[13:0], rk_sel[15:14]} ^ lnew;
        xy     = x_q ^ y_q;
        y_inv  = {xy[1:0], xy[15:2]};
        x_sub  = (x_q ^ rk_sel) - y_inv;
        x_inv  = {x_sub[8:0], x_sub[15:9]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = (ROUNDS > 1) ? EXPAND : DECRYPT;
            EXPAND:  if (cnt_q == LAST_EXP) state_d = DECRYPT;
            DECRYPT: if (cnt_q == 5'd0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        pt          = pt_q;
        debug_round = (state_q == EXPAND || state_q == DECRYPT) ? cnt_q : 5'd0;
    end

    // Datapath next-state.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        l_d      = l_q;
        cnt_d    = cnt_q;
        pt_d     = pt_q;
        rk_we    = 1'b0;
        rk_waddr = 5'd0;
        rk_wdata = 16'd0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d      = ct[31:16];
                    y_d      = ct[15:0];
                    l_d      = key[63:16];
                    cnt_d    = (ROUNDS > 1) ? 5'd0 : LAST_RND;
                    rk_we    = 1'b1;
                    rk_waddr = 5'd0;
                    rk_wdata = key[15:0];
                end
            end
            EXPAND: begin
                rk_we    = 1'b1;
                rk_waddr = cnt_q + 5'd1;
                rk_wdata = rk_new;
                l_d      = {lnew, l_q[47:16]};
                cnt_d    = (cnt_q == LAST_EXP) ? LAST_RND : cnt_q + 5'd1;
            end
            DECRYPT: begin
                x_d = x_inv;
                y_d = y_inv;
                if (cnt_q == 5'd0) pt_d = {x_inv, y_inv};
                else               cnt_d = cnt_q - 5'd1;
            end
            DONE: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            l_q   <= '0;
            cnt_q <= '0;
            pt_q  <= '0;
            for (int j = 0; j < ROUNDS; j++) rk_q[j] <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            l_q   <= l_d;
            cnt_q <= cnt_d;
            pt_q  <= pt_d;
            for (int j = 0; j < ROUNDS; j++) begin
                if (rk_we && rk_waddr == 5'(j)) rk_q[j] <= rk_wdata;
            end
        end
    end

endmodule

// File: tb/tb_speck_decrypt_iter.sv
`timescale 1ns/1ps
module tb_speck_decrypt_iter;

    localparam logic [63:0] K_STD  = 64'h1918111009080100;
    localparam logic [31:0] CT_STD = 32'hA86842F2;
    localparam logic [31:0] PT_STD = 32'h6574694C;
    localparam int          NREG   = 400;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // sel picks the instance under test: 0 -> ROUNDS=22, 1 -> ROUNDS=1, 2 -> ROUNDS=7
    logic [1:0]  sel = 2'd0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] ct = '0;
    logic [63:0] key = '0;
    logic        pending_next = 1'b0;
    int          rounds_tab [3] = '{22, 1, 7};

    logic [2:0]  in_valid_a, in_ready_a, out_valid_a;
    logic [31:0] pt_a [3];
    logic [4:0]  dbg_a [3];
    logic        in_ready_m, out_valid_m;
    logic [31:0] pt_m;
    logic [4:0]  dbg_m;

    logic [31:0] exp_q [$];
    logic [31:0] reg_ct [NREG];
    logic [63:0] reg_key [NREG];

    assign in_valid_a = {in_valid && sel == 2'd2, in_valid && sel == 2'd1, in_valid && sel == 2'd0};

    always_comb begin
        in_ready_m  = in_ready_a[sel];
        out_valid_m = out_valid_a[sel];
        pt_m        = pt_a[sel];
        dbg_m       = dbg_a[sel];
    end

    speck_decrypt_iter #(.ROUNDS(22)) u_r22 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .ct(ct), .key(key), .out_valid(out_valid_a[0]), .out_ready(out_ready),
        .pt(pt_a[0]), .debug_round(dbg_a[0])
    );
    speck_decrypt_iter #(.ROUNDS(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .ct(ct), .key(key), .out_valid(out_valid_a[1]), .out_ready(out_ready),
        .pt(pt_a[1]), .debug_round(dbg_a[1])
    );
    speck_decrypt_iter #(.ROUNDS(7)) u_r7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .ct(ct), .key(key), .out_valid(out_valid_a[2]), .out_ready(out_ready),
        .pt(pt_a[2]), .debug_round(dbg_a[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Forward SPECK32/64 encryption, used to build random vectors.
    function automatic logic [31:0] speck_enc(input logic [31:0] p, input logic [63:0] k, input int rounds);
        logic [15:0] x, y, a, ln;
        logic [15:0] l [3];
        x = p[31:16];
        y = p[15:0];
        a = k[15:0];
        l[0] = k[31:16];
        l[1] = k[47:32];
        l[2] = k[63:48];
        for (int i = 0; i < rounds; i++) begin
            x = ({x[6:0], x[15:7]} + y) ^ a;
            y = {y[13:0], y[15:14]} ^ x;
            if (i < rounds - 1) begin
                ln   = (a + {l[0][6:0], l[0][15:7]}) ^ 16'(i);
                a    = {a[13:0], a[15:14]} ^ ln;
                l[0] = l[1];
                l[1] = l[2];
                l[2] = ln;
            end
        end
        return {x, y};
    endfunction

    // debug_round expected n clock edges after the accept edge.
    function automatic logic [4:0] exp_dbg(input int n, input int r);
        if (n <= r - 2) return 5'(n);
        if (n <= 2 * r - 2) return 5'(2 * r - 2 - n);
        return 5'd0;
    endfunction

    // driver: offer ct/key and wait (bounded) for the accept edge
    task automatic do_accept(input logic [31:0] c, input logic [63:0] k);
        int waited = 0;
        ct = c;
        key = k;
        in_valid = 1'b1;
        while (in_ready_m !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_in_ready", 64'(in_ready_m), 64'd1);
        if (pending_next) chk("b2b_accept_delay", 64'(waited), 64'd0);
        pending_next = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ct = $urandom;
        key = {$urandom, $urandom};
    endtask

    // full transaction: accept, latency + debug_round sequence, optional stall, handshake
    task automatic run_txn(input logic [31:0] c, input logic [63:0] k, input int stall, input bit pulse,
                           input bit nxt, input logic [31:0] nc, input logic [63:0] nk);
        int r = rounds_tab[sel];
        int n = 0;
        bit dbg_ok = 1'b1;
        bit hold_ok = 1'b1;
        logic [31:0] exp_pt = '0;
        do_accept(c, k);
        @(negedge clk);
        while (1) begin
            if (dbg_m !== exp_dbg(n, r)) dbg_ok = 1'b0;
            if (out_valid_m === 1'b1 || n >= 200) break;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("out_latency", 64'(n), 64'(2 * r - 1));
        chk("debug_round_seq", 64'(dbg_ok), 64'd1);
        if (exp_q.size() > 0) exp_pt = exp_q.pop_front();
        chk("pt", 64'(pt_m), 64'(exp_pt));
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            if (pulse) in_valid = (s % 2 == 0);
            @(posedge clk);
            @(negedge clk);
            if (out_valid_m !== 1'b1 || pt_m !== exp_pt || in_ready_m !== 1'b0) hold_ok = 1'b0;
        end
        if (stall > 0) chk("backpressure_hold", 64'(hold_ok), 64'd1);
        in_valid = 1'b0;
        if (nxt) begin
            ct = nc;
            key = nk;
            in_valid = 1'b1;
            pending_next = 1'b1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("out_valid_drop", 64'(out_valid_m), 64'd0);
        chk("in_ready_after", 64'(in_ready_m), 64'd1);
    endtask

    initial begin
        logic [31:0] p2;
        logic [63:0] k2;
        logic [31:0] c2;
        logic [31:0] p_r;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready_m), 64'd1);
        chk("rst_out_valid", 64'(out_valid_m), 64'd0);
        chk("rst_pt", 64'(pt_m), 64'd0);
        chk("rst_debug", 64'(dbg_m), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // standard SPECK32/64 vector, no stall
        sel = 2'd0;
        exp_q.push_back(PT_STD);
        run_txn(CT_STD, K_STD, 0, 1'b0, 1'b0, '0, '0);

        // single round against the fixed FAF5 encryption-round key
        sel = 2'd1;
        exp_q.push_back(32'h00000000);
        run_txn(32'hFAF5FAF5, 64'h000000000000FAF5, 0, 1'b0, 1'b0, '0, '0);
        exp_q.push_back(32'h00010000);
        run_txn(32'hF8F5F8F5, 64'h000000000000FAF5, 2, 1'b0, 1'b0, '0, '0);

        // backpressure for 10 cycles with in_valid pulsed while busy
        sel = 2'd0;
        exp_q.push_back(PT_STD);
        run_txn(CT_STD, K_STD, 10, 1'b1, 1'b0, '0, '0);

        // reset well inside the inverse rounds aborts the operation
        do_accept(CT_STD, K_STD);
        repeat (30) @(posedge clk);
        #2;
        chk("pre_abort_debug", 64'(dbg_m), 64'(exp_dbg(30, 22)));
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid_m), 64'd0);
        chk("abort_pt", 64'(pt_m), 64'd0);
        chk("abort_in_ready", 64'(in_ready_m), 64'd1);
        chk("abort_debug", 64'(dbg_m), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_output", 64'(out_valid_m), 64'd0);
        exp_q.push_back(PT_STD);
        run_txn(CT_STD, K_STD, 0, 1'b0, 1'b0, '0, '0);

        // back-to-back: second vector queued during the first output handshake
        p2 = $urandom;
        k2 = {$urandom, $urandom};
        c2 = speck_enc(p2, k2, 22);
        exp_q.push_back(PT_STD);
        exp_q.push_back(p2);
        run_txn(CT_STD, K_STD, 0, 1'b0, 1'b1, c2, k2);
        run_txn(c2, k2, 0, 1'b0, 1'b0, '0, '0);

        // random regression with random output stalls, ROUNDS=22 then ROUNDS=7
        for (int cfg = 0; cfg < 2; cfg++) begin
            sel = (cfg == 0) ? 2'd0 : 2'd2;
            for (int i = 0; i < NREG; i++) begin
                p_r = $urandom;
                reg_key[i] = {$urandom, $urandom};
                reg_ct[i] = speck_enc(p_r, reg_key[i], rounds_tab[sel]);
                exp_q.push_back(p_r);
            end
            for (int i = 0; i < NREG; i++) begin
                run_txn(reg_ct[i], reg_key[i], $urandom_range(0, 3), 1'b0, i < NREG - 1,
                        reg_ct[(i < NREG - 1) ? i + 1 : i], reg_key[(i < NREG - 1) ? i + 1 : i]);
            end
        end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
